// File: rtl/dl_pkg.sv
// Shared types and helpers for the dl_* enable-chain blocks (tick generator, counter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dl_pkg;

    // Tick generator control states; the encoding is 2 bits wide so that stray codes fall back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } tick_state_e;

    // Tick generator repeat mode.
    typedef enum logic {
        TICK_PERIODIC = 1'b0,
        TICK_ONESHOT  = 1'b1
    } tick_mode_e;

    // A divide value of zero has no meaningful period, so it runs as the fastest legal rate.
    localparam int unsigned DIV_ZERO_MAP = 1;

    // Maps a requested divide value onto the value actually used by the divider.
    function automatic int unsigned div_map(input int unsigned d);
        return (d == 0) ? DIV_ZERO_MAP : d;
    endfunction

endpackage

// File: rtl/dl_counter.sv
// Saturating-wrap event counter: counts en strobes 0..MAX_VAL, then wraps to 0 with a done pulse.
// Latency: q and done update one edge after en is sampled high.
// Backpressure: none; every en strobe is counted.
module dl_counter #(
    parameter int unsigned NUM_BITS = 5,
    parameter int unsigned MAX_VAL  = 13
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    output logic [NUM_BITS-1:0] q_o,
    output logic                done_o
);

    logic [NUM_BITS-1:0] q_q;
    logic                done_q;

    // Count enabled edges; the wrap edge raises done for exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            q_q    <= '0;
            done_q <= 1'b0;
        end else if (en_i) begin
            if (q_q == NUM_BITS'(MAX_VAL)) begin
                q_q    <= '0;
                done_q <= 1'b1;
            end else begin
                q_q    <= q_q + NUM_BITS'(1);
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign q_o    = q_q;
    assign done_o = done_q;

endmodule

// File: rtl/dl_tick_gen.sv
// Programmable enable-strobe generator: one-cycle tick every div cycles, periodic or one-shot.
// Latency: start sampled at edge E0 gives the first tick from edge E0+div; tick and busy are registered.
// Backpressure: cfg_ready is low while running, so a config offer simply waits until IDLE.
module dl_tick_gen
    import dl_pkg::*;
#(
    parameter int unsigned DIV_BITS    = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [DIV_BITS-1:0] cfg_div_i,
    input  logic                cfg_oneshot_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                tick_o,
    output logic                busy_o
);

    localparam logic [DIV_BITS-1:0] RESET_DIV = DIV_BITS'(div_map(DEFAULT_DIV));

    tick_state_e         state_q;
    tick_mode_e          mode_q;
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] cnt_q;
    logic                tick_q;
    logic                busy_q;

    logic                cfg_hs;
    logic [DIV_BITS-1:0] cfg_div_eff;
    logic                cnt_last;

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_hs      = cfg_valid_i && cfg_ready_o;
    assign cfg_div_eff = DIV_BITS'(div_map(32'(cfg_div_i)));
    // cnt never exceeds div_q-1 and is cleared explicitly, so div_q = 2^DIV_BITS-1 cannot overflow it.
    assign cnt_last    = (cnt_q == (div_q - DIV_BITS'(1)));

    // Control FSM with the inline divider; stop outranks a due tick, one-shot returns to IDLE on its tick edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mode_q  <= TICK_PERIODIC;
            div_q   <= RESET_DIV;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tick_q <= 1'b0;
                    cnt_q  <= '0;
                    // A handshake on the start edge lands in div_q/mode_q before the run reads them.
                    if (cfg_hs) begin
                        div_q  <= cfg_div_eff;
                        mode_q <= tick_mode_e'(cfg_oneshot_i);
                    end
                    if (start_i && !stop_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        tick_q  <= 1'b0;
                    end else if (cnt_last) begin
                        tick_q <= 1'b1;
                        cnt_q  <= '0;
                        if (mode_q == TICK_ONESHOT) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tick_q <= 1'b0;
                        cnt_q  <= cnt_q + DIV_BITS'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tick_o = tick_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_dl_tick_gen.sv
// Bench for dl_tick_gen driving dl_counter; a tick-schedule model predicts tick/busy/ready and the counter.
// Latency: model expectations are evaluated at each rising edge and compared 1 time unit later.
// Backpressure: config offers are held until the model and DUT both report a handshake.
module tb_dl_tick_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic       cfg_oneshot;
    logic       start;
    logic       stop;
    logic       tick;
    logic       busy;
    logic [4:0] q;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dl_tick_gen #(.DIV_BITS(8), .DEFAULT_DIV(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_div_i     (cfg_div),
        .cfg_oneshot_i (cfg_oneshot),
        .start_i       (start),
        .stop_i        (stop),
        .tick_o        (tick),
        .busy_o        (busy)
    );

    dl_counter #(.NUM_BITS(5), .MAX_VAL(13)) u_cnt (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (tick),
        .q_o     (q),
        .done_o  (done)
    );

    // Reference model: a run is a start edge plus a period; ticks fall where elapsed edges are a multiple of it.
    int unsigned n_edge  = 0;
    int unsigned m_start = 0;
    int unsigned m_div   = 4;
    int unsigned tcnt    = 0;
    bit          m_run   = 1'b0;
    bit          m_one   = 1'b0;
    bit          e_tick  = 1'b0;
    bit          e_busy  = 1'b0;
    bit          e_ready = 1'b1;
    bit          e_done  = 1'b0;
    int unsigned e_q     = 0;

    task automatic model_edge();
        int unsigned el;
        n_edge++;
        if (!rst_n) begin
            m_run = 1'b0; m_div = 4; m_one = 1'b0; e_tick = 1'b0;
            tcnt = 0; e_q = 0; e_done = 1'b0;
        end else begin
            // The counter sees the tick that was visible during the cycle before this edge.
            if (e_tick) begin
                tcnt++;
                e_done = (tcnt % 14 == 0);
            end else begin
                e_done = 1'b0;
            end
            e_q = tcnt % 14;
            if (!m_run) begin
                e_tick = 1'b0;
                if (cfg_valid) begin
                    m_div = (cfg_div == 8'd0) ? 1 : 32'(cfg_div);
                    m_one = cfg_oneshot;
                end
                if (start && !stop) begin
                    m_run   = 1'b1;
                    m_start = n_edge;
                end
            end else begin
                el = n_edge - m_start;
                if (stop) begin
                    m_run  = 1'b0;
                    e_tick = 1'b0;
                end else if (el % m_div == 0) begin
                    e_tick = 1'b1;
                    if (m_one) m_run = 1'b0;
                end else begin
                    e_tick = 1'b0;
                end
            end
        end
        e_busy  = m_run;
        e_ready = !m_run;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int nt;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0; cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
            checks++; if (q !== 5'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
        end
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        nt = 0;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++;
            if (tick !== ((i % 4) == 0)) begin failures++; $display("FAIL default_div_tick i=%0d got=%b exp=%b", i, tick, (i % 4) == 0); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL default_div_busy i=%0d got=%b exp=1", i, busy); end
        end
        checks++; if (nt != 3) begin failures++; $display("FAIL default_div_count got=%0d exp=3", nt); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL default_stop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_periodic();
        int done_at;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cfg_valid = 1'b1; cfg_div = 8'd3; cfg_oneshot = 1'b0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (done === 1'b1 && done_at < 0) done_at = i;
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL periodic_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL periodic_busy i=%0d got=%b exp=%b", i, busy, e_busy); end
            checks++; if (q !== 5'(e_q)) begin failures++; $display("FAIL periodic_q i=%0d got=%0d exp=%0d", i, q, e_q); end
            checks++; if (done !== e_done) begin failures++; $display("FAIL periodic_done i=%0d got=%b exp=%b", i, done, e_done); end
        end
        // 14th tick is visible after edge 42; the counter wraps at edge 43.
        checks++; if (done_at != 43) begin failures++; $display("FAIL periodic_done_edge got=%0d exp=43", done_at); end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_oneshot();
        int nt;
        int first;
        cfg_valid = 1'b1; cfg_div = 8'd5; cfg_oneshot = 1'b1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        nt = 0; first = -1;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (tick === 1'b1) begin nt++; if (first < 0) first = i; end
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL oneshot_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
            checks++; if (busy !== (i < 5)) begin failures++; $display("FAIL oneshot_busy i=%0d got=%b exp=%b", i, busy, i < 5); end
        end
        checks++; if (nt != 1 || first != 5) begin failures++; $display("FAIL oneshot_count got=%0d@%0d exp=1@5", nt, first); end
        cfg_valid = 1'b1; cfg_div = 8'd0; cfg_oneshot = 1'b1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        nt = 0; first = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (tick === 1'b1) begin nt++; if (first < 0) first = i; end
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL div0_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
            checks++; if (cfg_ready !== e_ready) begin failures++; $display("FAIL div0_ready i=%0d got=%b exp=%b", i, cfg_ready, e_ready); end
        end
        checks++; if (nt != 1 || first != 1) begin failures++; $display("FAIL div0_count got=%0d@%0d exp=1@1", nt, first); end
    endtask

    task automatic test_stop();
        int nt;
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_oneshot = 1'b0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL stop_beats_tick got=%b exp=0", tick); end
        checks++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin failures++; $display("FAIL stop_idle busy=%b ready=%b exp=0/1", busy, cfg_ready); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        nt = 0;
        for (int i = 7; i <= 14; i++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL restart_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
            checks++; if (tick !== (i == 10 || i == 14)) begin failures++; $display("FAIL restart_sched i=%0d got=%b", i, tick); end
        end
        checks++; if (nt != 2) begin failures++; $display("FAIL restart_count got=%0d exp=2", nt); end
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_start_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_cfg_gating();
        int nt;
        cfg_valid = 1'b1; cfg_div = 8'd4; cfg_oneshot = 1'b0; start = 1'b1;
        step();
        start = 1'b0; cfg_div = 8'd2;
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL gate_ready i=%0d got=%b exp=0", i, cfg_ready); end
            checks++; if (tick !== ((i % 4) == 0)) begin failures++; $display("FAIL gate_period i=%0d got=%b exp=%b", i, tick, (i % 4) == 0); end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        nt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++; if (tick !== ((i % 2) == 0)) begin failures++; $display("FAIL gate_newdiv i=%0d got=%b exp=%b", i, tick, (i % 2) == 0); end
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL gate_model i=%0d got=%b exp=%b", i, tick, e_tick); end
        end
        checks++; if (nt != 4) begin failures++; $display("FAIL gate_count got=%0d exp=4", nt); end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int nt;
        cfg_valid = 1'b1; cfg_div = 8'd2; cfg_oneshot = 1'b0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (tick !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrun_reset tick=%b busy=%b exp=0/0", tick, busy); end
        checks++; if (cfg_ready !== 1'b1 || q !== 5'd0) begin failures++; $display("FAIL midrun_reset ready=%b q=%0d exp=1/0", cfg_ready, q); end
        start = 1'b1;
        step();
        start = 1'b0;
        nt = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL midrun_after i=%0d got=%b exp=%b", i, tick, e_tick); end
        end
        checks++; if (nt != 2) begin failures++; $display("FAIL midrun_default_div ticks=%0d exp=2", nt); end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_max_div();
        int nt;
        int first;
        cfg_valid = 1'b1; cfg_div = 8'd255; cfg_oneshot = 1'b0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        nt = 0; first = -1;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (tick === 1'b1) begin nt++; if (first < 0) first = i; end
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL maxdiv_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
        end
        checks++; if (nt != 1 || first != 255) begin failures++; $display("FAIL maxdiv_sched got=%0d@%0d exp=1@255", nt, first); end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_div     = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            cfg_oneshot = ($urandom_range(0, 2) == 0);
            start       = ($urandom_range(0, 5) == 0);
            stop        = ($urandom_range(0, 24) == 0);
            step();
            checks++; if (tick !== e_tick) begin failures++; $display("FAIL rand_tick i=%0d got=%b exp=%b", i, tick, e_tick); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, e_busy); end
            checks++; if (cfg_ready !== e_ready) begin failures++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, cfg_ready, e_ready); end
            checks++; if (q !== 5'(e_q) || done !== e_done) begin failures++; $display("FAIL rand_counter i=%0d q=%0d done=%b exp=%0d/%b", i, q, done, e_q, e_done); end
        end
        rst_n = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop();
        test_cfg_gating();
        test_reset_midrun();
        test_max_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl_tick_gen.md
Name: dl_tick_gen

Overview:
Programmable enable-strobe generator that sits directly upstream of dl_counter and drives its en input. It emits a one-cycle tick every DIV cycles, either periodically or once. Software or a controlling FSM configures it through a valid/ready port and starts or stops it with single-cycle pulses. It replaces free-running random en stimulus with a deterministic, rate-controlled enable.

Parameters:
DIV_BITS, 8, width of the divide value.
DEFAULT_DIV, 4, divide value loaded at reset; must fit in DIV_BITS.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
cfg_valid  in  1  config offer.
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready; equals (state == IDLE).
cfg_div  in  DIV_BITS  divide value; 0 is treated as 1.
cfg_oneshot  in  1  0 = periodic, 1 = one-shot.
start  in  1  pulse; begins RUN from IDLE.
stop  in  1  pulse; aborts RUN.
tick  out  1  registered one-cycle strobe; connects to dl_counter en.
busy  out  1  registered; high while state == RUN.

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE, div_q = DEFAULT_DIV, mode_q = periodic, cnt = 0.
  - tick = 0, busy = 0; cfg_ready = 1 (combinational from IDLE).
- States: IDLE, RUN. No other states; illegal encodings return to IDLE.
- IDLE:
  - A cfg handshake loads div_q = (cfg_div == 0 ? 1 : cfg_div) and mode_q = cfg_oneshot.
  - start moves to RUN with cnt = 0. tick stays 0.
  - If cfg handshake and start occur on the same edge, the new cfg applies to this run.
- RUN, at each edge:
  - If cnt == div_q-1: tick <= 1, cnt <= 0; else tick <= 0, cnt <= cnt+1.
  - cfg_ready = 0; cfg_valid is ignored with no handshake, so the offer stays pending.
  - start is ignored; there is no restart.
- Latency: start sampled at edge E0, first tick high from edge E0+div_q for exactly one cycle.
  - Periodic mode: subsequent ticks every div_q cycles.
  - div_q = 1 gives tick continuously high from E0+1.
- One-shot: on the edge that asserts tick, state <= IDLE and busy <= 0. tick returns to 0 at the next edge.
- stop in RUN: state <= IDLE, cnt <= 0, tick <= 0 at that edge, even if a tick was due.
  - stop beats a due tick.
  - stop in IDLE has no effect.
  - stop and start together in IDLE: stay IDLE.
- cnt is DIV_BITS wide; wrap is by explicit clear only, never by overflow. div_q = 2^DIV_BITS-1 is legal.
- Mid-run reset: rst_n low forces IDLE and all reset values at that edge, with no residual tick.

Decomposition:
- Shared package dl_pkg:
  - tick_state_e {IDLE, RUN}.
  - tick_mode_e {TICK_PERIODIC, TICK_ONESHOT}.
  - Localparam helper for the div==0→1 mapping.
- No sub-module. The divider is inline because it needs runtime load and clear.
- dl_counter is not reused here because its MAX_VAL is elaboration-time only.
- Bench instantiates dl_tick_gen → dl_counter (NUM_BITS=5, MAX_VAL=13) to check the chain.

Test Plan:
- Reset defaults:
  - Stimulus: hold rst_n=0 for 2 cycles, then start at E0 with no cfg.
  - Response: tick=0, busy=0, cfg_ready=1 during reset; ticks at E0+4, E0+8, E0+12 (DEFAULT_DIV=4).
- Periodic rate:
  - Stimulus: cfg_div=3, cfg_oneshot=0, then start; drive dl_counter.
  - Response: ticks every 3 cycles. dl_counter q steps 0→1→…→13 with done after 14 ticks, i.e. 42 cycles after the first tick edge minus 3.
- One-shot and div=0:
  - Stimulus: cfg_div=5, oneshot=1, start at E0.
  - Response: single tick at E0+5; busy falls at the same edge; no further ticks over 20 cycles.
  - Stimulus: repeat with cfg_div=0 → single tick at E0+1.
- Stop priority:
  - Stimulus: div=4, start at E0, stop at E0+4.
  - Response: no tick at E0+4; state IDLE, busy=0; start at E0+6 gives next tick at E0+10.
- Config gating:
  - Stimulus: in RUN with div=4, assert cfg_valid with cfg_div=2.
  - Response: cfg_ready=0, period stays 4; after stop, handshake completes and the next run ticks every 2 cycles.
- Reset mid-run:
  - Stimulus: div=2 periodic, rst_n=0 at E0+3 for 1 cycle.
  - Response: tick=0, busy=0 from E0+3; div_q back to 4 (verified by a subsequent start).
